// File: rtl/game_state_if.sv
`default_nettype none
// ============================================================================
// Module      : game_state_if
// Description : Control/status bundle between the game supervisor and its
//               neighbours (display timing, collision logic, sprite/pixel mux).
// Revision    : 1.0 - initial release
// ============================================================================
interface game_state_if;
  logic       vSync;      // active-low vertical sync, frame boundary source
  logic       death_in;   // any enemy overlaps bomberman
  logic       start_in;   // OR of raw direction buttons
  logic [2:0] lives;
  logic       game_over;
  logic       dying;
  logic       respawn;
  logic       invuln;
  logic       flash_on;
  logic       playing;

  // Environment side: drives frame timing and game events, observes status.
  modport master (
    output vSync, death_in, start_in,
    input  lives, game_over, dying, respawn, invuln, flash_on, playing
  );

  // Supervisor side.
  modport slave (
    input  vSync, death_in, start_in,
    output lives, game_over, dying, respawn, invuln, flash_on, playing
  );
endinterface
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_state_ctrl
// Description : Game-level supervisor. Tracks lives, times the death animation
//               and post-respawn invulnerability in video frames, and issues
//               game_over / dying / respawn / sprite-flash / playing controls.
// Revision    : 1.0 - initial release
// ============================================================================
module game_state_ctrl #(
  parameter int LIVES_INIT    = 3,    // 1..7
  parameter int DEATH_FRAMES  = 60,   // >= 1, <= 255
  parameter int INVULN_FRAMES = 120,  // >= 1, <= 255
  parameter int FLASH_BIT     = 3     // 0..7
) (
  input  wire logic    sys_clk,
  input  wire logic    Reset,
  game_state_if.slave  gs
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_DYING   = 3'd2,
    S_RESPAWN = 3'd3,
    S_INVULN  = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [2:0] c_lives_init  = 3'(LIVES_INIT);
  localparam logic [7:0] c_death_last  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] c_invuln_last = 8'(INVULN_FRAMES - 1);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vsync_q, vsync_d;
  logic       game_over_q, game_over_d;
  logic       dying_q, dying_d;
  logic       respawn_q, respawn_d;
  logic       invuln_q, invuln_d;
  logic       flash_on_q, flash_on_d;
  logic       playing_q, playing_d;

  // One pulse on the first low cycle of vSync: previous sample high, now low.
  logic frame_strobe;
  assign frame_strobe = vsync_q & ~gs.vSync;
  assign vsync_d      = gs.vSync;

  // Next-state, lives and frame counter; outputs decode the next state so
  // they line up with the cycle the state register changes.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (gs.start_in) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Death takes priority; a coincident strobe is discarded by the
        // counter clear on state entry below.
        if (gs.death_in) begin
          state_d = S_DYING;
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        end
      end
      S_DYING: begin
        if (frame_strobe && (frame_cnt_q == c_death_last))
          state_d = (lives_q == 3'd0) ? S_OVER : S_RESPAWN;
      end
      S_RESPAWN: begin
        state_d = S_INVULN;
      end
      S_INVULN: begin
        if (frame_strobe && (frame_cnt_q == c_invuln_last))
          state_d = S_PLAY;
      end
      S_OVER: begin
        lives_d = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q)
      frame_cnt_d = 8'd0;
    else if (frame_strobe)
      frame_cnt_d = frame_cnt_q + 8'd1;

    game_over_d = (state_d == S_OVER);
    dying_d     = (state_d == S_DYING);
    respawn_d   = (state_d == S_RESPAWN);
    invuln_d    = (state_d == S_INVULN);
    playing_d   = (state_d == S_PLAY) || (state_d == S_INVULN);
    // Sprite blinks only while invulnerable, phase from the frame counter.
    flash_on_d  = (state_d != S_INVULN) || !frame_cnt_d[FLASH_BIT];
  end

  // State, counters and registered outputs; async reset returns to IDLE.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      lives_q     <= c_lives_init;
      frame_cnt_q <= 8'd0;
      vsync_q     <= 1'b1;
      game_over_q <= 1'b0;
      dying_q     <= 1'b0;
      respawn_q   <= 1'b0;
      invuln_q    <= 1'b0;
      flash_on_q  <= 1'b1;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      game_over_q <= game_over_d;
      dying_q     <= dying_d;
      respawn_q   <= respawn_d;
      invuln_q    <= invuln_d;
      flash_on_q  <= flash_on_d;
      playing_q   <= playing_d;
    end
  end

  assign gs.lives     = lives_q;
  assign gs.game_over = game_over_q;
  assign gs.dying     = dying_q;
  assign gs.respawn   = respawn_q;
  assign gs.invuln    = invuln_q;
  assign gs.flash_on  = flash_on_q;
  assign gs.playing   = playing_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_state_ctrl
// Description : Self-checking bench for game_state_ctrl. Expected output
//               vectors {lives,game_over,dying,respawn,invuln,flash_on,playing}
//               are queued as stimulus is applied and popped on response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_state_ctrl;

  logic sys_clk = 1'b0;
  logic Reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   vs_phase = 50;
  int   resp_cnt = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  logic [8:0] e;
  string      nm;

  game_state_if gs_if();

  game_state_ctrl #(
    .LIVES_INIT(2), .DEATH_FRAMES(2), .INVULN_FRAMES(4), .FLASH_BIT(1)
  ) dut (
    .sys_clk(sys_clk),
    .Reset  (Reset),
    .gs     (gs_if)
  );

  wire [8:0] obs = {gs_if.lives, gs_if.game_over, gs_if.dying, gs_if.respawn,
                    gs_if.invuln, gs_if.flash_on, gs_if.playing};

  always #5 sys_clk = ~sys_clk;

  // vSync: period 100 cycles, low for phases 0 and 1.
  initial begin
    gs_if.vSync = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      vs_phase = (vs_phase == 99) ? 0 : vs_phase + 1;
      gs_if.vSync = (vs_phase >= 2);
    end
  end

  // Counts respawn-high cycles (value seen at each edge is the prior cycle's).
  always @(posedge sys_clk) if (gs_if.respawn === 1'b1) resp_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [8:0] ev(input logic [2:0] l, input logic go, input logic dy,
                                    input logic rs, input logic iv, input logic fl, input logic pl);
    return {l, go, dy, rs, iv, fl, pl};
  endfunction

  // Returns just after the clock edge that consumed the next frame strobe.
  task automatic wait_strobe();
    int n = 0;
    while (n < 300) begin
      @(negedge sys_clk);
      if (vs_phase == 0) break;
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: got no vSync fall in 300 cycles want one");
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; gs_if.death_in = 1'b0; gs_if.start_in = 1'b0;
    repeat (3) @(posedge sys_clk); #1;
    Reset = 1'b0;
    exp_q.push_back(ev(3'd2, 0, 0, 0, 0, 1, 0)); name_q.push_back("reset_state");
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    @(posedge sys_clk); #1; gs_if.death_in = 1'b1;
    exp_q.push_back(ev(3'd2, 0, 0, 0, 0, 1, 0)); name_q.push_back("idle_death_ignored");
    repeat (3) @(posedge sys_clk); #1; gs_if.death_in = 1'b0;
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    @(posedge sys_clk); #1; gs_if.start_in = 1'b1;
    exp_q.push_back(ev(3'd2, 0, 0, 0, 0, 1, 1)); name_q.push_back("start_to_play");
    @(posedge sys_clk); #1; gs_if.start_in = 1'b0;
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
  endtask

  task automatic test_death_respawn();
    int r0;
    @(posedge sys_clk); #1; gs_if.death_in = 1'b1;
    exp_q.push_back(ev(3'd1, 0, 1, 0, 0, 1, 0)); name_q.push_back("death_dying");
    @(posedge sys_clk); #1; gs_if.death_in = 1'b0;
    r0 = resp_cnt;
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    exp_q.push_back(ev(3'd1, 0, 1, 0, 0, 1, 0)); name_q.push_back("dying_after_1_strobe");
    wait_strobe();
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    exp_q.push_back(ev(3'd1, 0, 0, 1, 0, 1, 0)); name_q.push_back("respawn_pulse");
    exp_q.push_back(ev(3'd1, 0, 0, 0, 1, 1, 1)); name_q.push_back("invuln_entry");
    wait_strobe();
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    end
    checks++;
    if (resp_cnt - r0 !== 1) begin
      errors++; $display("FAIL respawn_width: got %0d cycles want 1", resp_cnt - r0);
    end
  endtask

  task automatic test_invuln();
    logic [1:0] kb;
    @(posedge sys_clk); #1; gs_if.death_in = 1'b1;
    exp_q.push_back(ev(3'd1, 0, 0, 0, 1, 1, 1)); name_q.push_back("invuln_death_masked");
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    for (int k = 1; k <= 3; k++) begin
      kb = 2'(k);
      exp_q.push_back(ev(3'd1, 0, 0, 0, 1, ~kb[1], 1)); name_q.push_back("invuln_flash");
      wait_strobe();
      @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s(frame %0d): got %b want %b", nm, k, obs, e); end
    end
    exp_q.push_back(ev(3'd1, 0, 0, 0, 0, 1, 1)); name_q.push_back("invuln_to_play");
    exp_q.push_back(ev(3'd0, 0, 1, 0, 0, 1, 0)); name_q.push_back("held_death_redies");
    wait_strobe();
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    end
  endtask

  task automatic test_game_over();
    int r0;
    r0 = resp_cnt;
    exp_q.push_back(ev(3'd0, 0, 1, 0, 0, 1, 0)); name_q.push_back("last_dying_1_strobe");
    exp_q.push_back(ev(3'd0, 1, 0, 0, 0, 1, 0)); name_q.push_back("game_over");
    for (int i = 0; i < 2; i++) begin
      wait_strobe();
      @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    end
    for (int c = 0; c < 1000; c++) begin
      @(posedge sys_clk); #1;
      gs_if.start_in = 1'($urandom); gs_if.death_in = 1'($urandom);
      exp_q.push_back(ev(3'd0, 1, 0, 0, 0, 1, 0)); name_q.push_back("over_hold");
      @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s(cycle %0d): got %b want %b", nm, c, obs, e); end
    end
    gs_if.start_in = 1'b0; gs_if.death_in = 1'b0;
    checks++;
    if (resp_cnt !== r0) begin
      errors++; $display("FAIL over_no_respawn: got %0d pulses want 0", resp_cnt - r0);
    end
  endtask

  task automatic test_coincident();
    int n = 0;
    @(posedge sys_clk); #1; Reset = 1'b1;
    @(posedge sys_clk); #1; Reset = 1'b0; gs_if.start_in = 1'b1;
    exp_q.push_back(ev(3'd2, 0, 0, 0, 0, 1, 1)); name_q.push_back("coinc_play");
    @(posedge sys_clk); #1; gs_if.start_in = 1'b0;
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    while (vs_phase != 99 && n < 300) begin @(negedge sys_clk); n++; end
    @(posedge sys_clk); #1; gs_if.death_in = 1'b1;   // vSync falls on this same edge
    exp_q.push_back(ev(3'd1, 0, 1, 0, 0, 1, 0)); name_q.push_back("coinc_dying");
    exp_q.push_back(ev(3'd1, 0, 1, 0, 0, 1, 0)); name_q.push_back("coinc_dying_after_1");
    exp_q.push_back(ev(3'd1, 0, 0, 1, 0, 1, 0)); name_q.push_back("coinc_respawn_after_2");
    exp_q.push_back(ev(3'd1, 0, 0, 0, 1, 1, 1)); name_q.push_back("coinc_invuln");
    @(posedge sys_clk); #1; gs_if.death_in = 1'b0;
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    for (int i = 0; i < 2; i++) begin
      wait_strobe();
      @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    end
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
  endtask

  task automatic test_reset_invuln();
    int r0;
    exp_q.push_back(ev(3'd1, 0, 0, 0, 1, 1, 1)); name_q.push_back("mid_invuln");
    wait_strobe();
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    r0 = resp_cnt;
    @(posedge sys_clk); #1; Reset = 1'b1;
    exp_q.push_back(ev(3'd2, 0, 0, 0, 0, 1, 0)); name_q.push_back("reset_abort_idle");
    exp_q.push_back(ev(3'd2, 0, 0, 0, 0, 1, 0)); name_q.push_back("idle_after_reset");
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    repeat (3) @(posedge sys_clk); #1; Reset = 1'b0;
    repeat (250) @(posedge sys_clk);
    @(negedge sys_clk); nm = name_q.pop_front(); e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %b want %b", nm, obs, e); end
    checks++;
    if (resp_cnt !== r0) begin
      errors++; $display("FAIL reset_no_respawn: got %0d pulses want 0", resp_cnt - r0);
    end
  endtask

  initial begin
    gs_if.death_in = 1'b0;
    gs_if.start_in = 1'b0;
    test_reset();
    test_death_respawn();
    test_invuln();
    test_game_over();
    test_coincident();
    test_reset_invuln();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
